// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// FETCH/WAIT/HOLD controller talking to a ready-based instruction memory.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   PC_Write            : 0 stalls the PC (hazard detection)
//   IF_ID_Write         : 0 holds the IF/ID register (hazard detection)
//   branch_taken        : redirect from EX; flushes IF/ID
//   branch_target       : redirect address (word aligned on use)
//   imem_req/imem_addr  : instruction memory request and address (= pc)
//   imem_ready/rdata    : memory completion and returned instruction
//   pc_ID/instr_ID      : IF/ID payload
//   valid_ID            : 1 = real instruction, 0 = bubble
//   fetch_pending       : 1 while waiting on the memory
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_Write,
  input  logic        IF_ID_Write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_ID,
  output logic [31:0] instr_ID,
  output logic        valid_ID,
  output logic        fetch_pending
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pc_id_q, pc_id_d;
  logic [XLEN-1:0]   instr_id_q, instr_id_d;
  logic              valid_id_q, valid_id_d;
  logic [XLEN-1:0]   buf_q, buf_d;
  logic [XLEN-1:0]   pc_plus4;
  logic              advance;

  assign pc_plus4 = pc_q + XLEN'(4);
  assign advance  = PC_Write && IF_ID_Write;

  // Next-state and IF/ID update; a taken branch overrides everything.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_id_d    = pc_id_q;
    instr_id_d = instr_id_q;
    valid_id_d = valid_id_q;
    buf_d      = buf_q;

    if (branch_taken) begin
      pc_d       = {branch_target[31:2], 2'b00};
      pc_id_d    = '0;
      instr_id_d = NOP_INSTR;
      valid_id_d = 1'b0;
      buf_d      = '0;
      state_d    = FETCH;
    end else begin
      case (state_q)
        FETCH, WAIT: begin
          if (!imem_ready) begin
            state_d = WAIT;
            if (IF_ID_Write) begin
              pc_id_d    = pc_q;
              instr_id_d = NOP_INSTR;
              valid_id_d = 1'b0;
            end
          end else if (advance) begin
            pc_id_d    = pc_q;
            instr_id_d = imem_rdata;
            valid_id_d = 1'b1;
            pc_d       = pc_plus4;
            state_d    = FETCH;
          end else begin
            // Memory has completed but the pipeline is stalled: park the data.
            buf_d   = imem_rdata;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (advance) begin
            pc_id_d    = pc_q;
            instr_id_d = buf_q;
            valid_id_d = 1'b1;
            pc_d       = pc_plus4;
            state_d    = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      pc_id_q    <= '0;
      instr_id_q <= NOP_INSTR;
      valid_id_q <= 1'b0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_id_q    <= pc_id_d;
      instr_id_q <= instr_id_d;
      valid_id_q <= valid_id_d;
      buf_q      <= buf_d;
    end
  end

  // Request is gated by reset so nothing is issued while rst_n is low.
  assign imem_req      = rst_n && (state_q != HOLD);
  assign imem_addr     = pc_q;
  assign pc_ID         = pc_id_q;
  assign instr_ID      = instr_id_q;
  assign valid_ID      = valid_id_q;
  assign fetch_pending = (state_q == WAIT);

endmodule
